// File: rtl/i2c_target_regs.sv
// I2C target with a byte-addressed register file.
// The first byte written after the address byte sets the register pointer.
// Later bytes are written to, or read from, the register file.
// The pointer auto-increments after each data byte and wraps at DEPTH.
// SDA is only ever pulled low through sda_oe (open-drain), and only while SCL is low.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         DEPTH    = 128,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic                     wr_stb,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REG       = 4'd3;
    localparam logic [3:0] S_REG_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0] r_state;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_ack_ph;
    logic       r_rw;
    logic [7:0] r_mem [DEPTH];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
    logic [7:0] w_byte;
    logic [7:0] w_rd_byte;

    // Pointer increment with wrap at DEPTH-1 (also correct for non power-of-two depths)
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_last_bit = (r_bitcnt == 3'd7);
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_rd_byte  = r_mem[ptr];

    // Protocol FSM: bits are shifted in on SCL rise, and SDA is updated on SCL fall
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_ack_ph <= 1'b0;
            r_rw     <= 1'b0;
            sda_oe   <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            busy     <= 1'b0;
            ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
        end else begin
            wr_stb <= 1'b0;
            if (w_stop) begin
                r_state  <= S_IDLE;
                r_bitcnt <= 3'd0;
                r_ack_ph <= 1'b0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else if (w_start) begin
                // A repeated START keeps busy; the following address byte decides it
                r_state  <= S_ADDR;
                r_bitcnt <= 3'd0;
                r_ack_ph <= 1'b0;
                sda_oe   <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_REG, S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last_bit) begin
                                if (r_state == S_ADDR) begin
                                    if (w_byte[7:1] == DEV_ADDR) begin
                                        r_state <= S_ADDR_ACK;
                                        r_rw    <= w_byte[0];
                                        busy    <= 1'b1;
                                    end else begin
                                        r_state <= S_IDLE;
                                        busy    <= 1'b0;
                                    end
                                end else if (r_state == S_REG) begin
                                    ptr     <= w_byte[PW-1:0];
                                    r_state <= S_REG_ACK;
                                end else begin
                                    r_mem[ptr] <= w_byte;
                                    wr_stb     <= 1'b1;
                                    wr_addr    <= ptr;
                                    wr_data    <= w_byte;
                                    ptr        <= f_ptr_inc(ptr);
                                    r_state    <= S_WDATA_ACK;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                        // First fall pulls SDA low for the ACK; second fall ends the slot
                        if (w_scl_fall) begin
                            if (!r_ack_ph) begin
                                sda_oe   <= 1'b1;
                                r_ack_ph <= 1'b1;
                            end else begin
                                r_ack_ph <= 1'b0;
                                if ((r_state == S_ADDR_ACK) && r_rw) begin
                                    // This fall is also the start of read bit 7
                                    r_state <= S_RDATA;
                                    r_shift <= {w_rd_byte[6:0], 1'b0};
                                    sda_oe  <= ~w_rd_byte[7];
                                end else begin
                                    sda_oe  <= 1'b0;
                                    r_state <= (r_state == S_ADDR_ACK) ? S_REG : S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_fall) begin
                            sda_oe  <= ~r_shift[7];
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last_bit) begin
                                ptr     <= f_ptr_inc(ptr);
                                r_state <= S_RDATA_ACK;
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (w_scl_fall) sda_oe <= 1'b0;
                        if (w_scl_rise) begin
                            if (!r_sda_s2) begin
                                r_shift <= w_rd_byte;
                                r_state <= S_RDATA;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master on an open-drain bus.
// It includes a register-file/pointer reference model.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    localparam int DEPTH = 128;
    localparam int Q     = 60;   // quarter SCL period in ns (SCL = clk/24)

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       bus_sda;
    logic       sda_oe, wr_stb, busy;
    logic [6:0] wr_addr, ptr;
    logic [7:0] wr_data;

    assign bus_sda = m_sda & ~sda_oe;

    i2c_target_regs #(.DEV_ADDR(7'h50), .DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(bus_sda), .sda_oe(sda_oe),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .ptr(ptr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents, pointer, expected write strobes
    logic [7:0] mdl_mem [DEPTH];
    int         mdl_ptr;
    logic [6:0] exp_addr_q[$];
    logic [7:0] exp_data_q[$];
    logic [6:0] got_addr_q[$];
    logic [7:0] got_data_q[$];
    logic [7:0] tx_data [8];
    logic [7:0] rx_data [8];

    int   oe_hi_cnt = 0;
    int   oe_viol   = 0;
    bit   mon_en    = 1'b0;
    logic prev_oe   = 1'b0;

    // Write strobe capture, open-drain activity count, and SDA-while-SCL-high watch
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            got_addr_q.push_back(wr_addr);
            got_data_q.push_back(wr_data);
        end
        if (sda_oe === 1'b1) oe_hi_cnt++;
        if (mon_en && m_scl && (sda_oe !== prev_oe)) oe_viol++;
        prev_oe = sda_oe;
    end

    task automatic clear_q();
        exp_addr_q.delete(); exp_data_q.delete();
        got_addr_q.delete(); got_data_q.delete();
    endtask

    task automatic model_write(input logic [7:0] regp, input int n);
        mdl_ptr = int'(regp) % DEPTH;
        for (int i = 0; i < n; i++) begin
            mdl_mem[mdl_ptr] = tx_data[i];
            exp_addr_q.push_back(7'(mdl_ptr));
            exp_data_q.push_back(tx_data[i]);
            mdl_ptr = (mdl_ptr + 1) % DEPTH;
        end
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_sda = b; #Q;
        m_scl = 1'b1; #Q;
        s = bus_sda; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        logic [7:0] v;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            v[i] = s;
        end
        bus_bit(~mack, s);
        d = v;
    endtask

    // Full write transaction: START, A0, pointer, n data bytes, STOP
    task automatic do_write(input logic [7:0] regp, input int n, output int nacks);
        logic a;
        nacks = 0;
        bus_start();
        wr_byte(8'hA0, a); if (!a) nacks++;
        wr_byte(regp, a);  if (!a) nacks++;
        for (int i = 0; i < n; i++) begin
            wr_byte(tx_data[i], a); if (!a) nacks++;
        end
        bus_stop();
        #(4*Q);
    endtask

    // Read n bytes; optionally set the pointer first, using a repeated START
    task automatic do_read(input bit set_ptr, input logic [7:0] regp, input int n, output int nacks);
        logic a;
        logic [7:0] d;
        nacks = 0;
        bus_start();
        if (set_ptr) begin
            wr_byte(8'hA0, a); if (!a) nacks++;
            wr_byte(regp, a);  if (!a) nacks++;
            bus_start();
        end
        wr_byte(8'hA1, a); if (!a) nacks++;
        for (int i = 0; i < n; i++) begin
            rd_byte(i != n - 1, d);
            rx_data[i] = d;
        end
        bus_stop();
        #(4*Q);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (sda_oe !== 1'b0)   begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end n_checks++;
        if (wr_stb !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_stb got %b want 0", wr_stb); end n_checks++;
        if (wr_addr !== 7'h00) begin n_fail++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end n_checks++;
        if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got %h want 00", wr_data); end n_checks++;
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end n_checks++;
        if (ptr !== 7'h00)     begin n_fail++; $display("FAIL reset_ptr got %h want 00", ptr); end n_checks++;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
        mdl_ptr = 0;
        @(negedge clk) rst = 1'b1;
        repeat (5) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_write_basic();
        logic a0, a1, a2, a3;
        clear_q();
        bus_start();
        wr_byte(8'hA0, a0);
        if (busy !== 1'b1) begin n_fail++; $display("FAIL wb_busy got %b want 1", busy); end n_checks++;
        wr_byte(8'h05, a1);
        wr_byte(8'h3C, a2);
        wr_byte(8'h7E, a3);
        bus_stop();
        #(4*Q);
        tx_data[0] = 8'h3C; tx_data[1] = 8'h7E;
        model_write(8'h05, 2);
        if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL wb_acks got %b want 1111", {a0, a1, a2, a3}); end n_checks++;
        if (got_addr_q.size() != 2) begin
            n_fail++; $display("FAIL wb_strobe_count got %0d want 2", got_addr_q.size());
        end else begin
            if ({got_addr_q[0], got_data_q[0]} !== {7'h05, 8'h3C}) begin n_fail++; $display("FAIL wb_strobe0 got %h/%h want 05/3c", got_addr_q[0], got_data_q[0]); end
            n_checks++;
            if ({got_addr_q[1], got_data_q[1]} !== {7'h06, 8'h7E}) begin n_fail++; $display("FAIL wb_strobe1 got %h/%h want 06/7e", got_addr_q[1], got_data_q[1]); end
        end
        n_checks++;
        if (ptr !== 7'd7) begin n_fail++; $display("FAIL wb_ptr got %0d want 7", ptr); end n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wb_busy_after_stop got %b want 0", busy); end n_checks++;
    endtask

    task automatic test_repeated_start_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        bus_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h05, a1);
        bus_start();
        wr_byte(8'hA1, a2);
        rd_byte(1'b1, d0);
        rd_byte(1'b0, d1);
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rs_busy_after_nack got %b want 0", busy); end n_checks++;
        bus_stop();
        #(4*Q);
        mdl_ptr = 7;
        if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rs_acks got %b want 111", {a0, a1, a2}); end n_checks++;
        if (d0 !== 8'h3C) begin n_fail++; $display("FAIL rs_data0 got %h want 3c", d0); end n_checks++;
        if (d1 !== 8'h7E) begin n_fail++; $display("FAIL rs_data1 got %h want 7e", d1); end n_checks++;
        if (ptr !== 7'd7) begin n_fail++; $display("FAIL rs_ptr got %0d want 7", ptr); end n_checks++;
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1;
        int oe_before;
        oe_before = oe_hi_cnt;
        bus_start();
        wr_byte(8'hA2, a0);
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mm_busy got %b want 0", busy); end n_checks++;
        wr_byte(8'h00, a1);
        bus_stop();
        #(4*Q);
        if (a0 !== 1'b0) begin n_fail++; $display("FAIL mm_addr_ack got %b want 0", a0); end n_checks++;
        if (a1 !== 1'b0) begin n_fail++; $display("FAIL mm_next_ack got %b want 0", a1); end n_checks++;
        if (oe_hi_cnt !== oe_before) begin n_fail++; $display("FAIL mm_sda_driven got %0d cycles want 0", oe_hi_cnt - oe_before); end n_checks++;
        if (ptr !== 7'(mdl_ptr)) begin n_fail++; $display("FAIL mm_ptr got %0d want %0d", ptr, mdl_ptr); end n_checks++;
    endtask

    task automatic test_wrap();
        int nk;
        clear_q();
        tx_data[0] = 8'h11; tx_data[1] = 8'h22;
        do_write(8'h7F, 2, nk);
        model_write(8'h7F, 2);
        if (nk != 0) begin n_fail++; $display("FAIL wrap_acks got %0d nacks want 0", nk); end n_checks++;
        if (got_addr_q.size() != 2) begin
            n_fail++; $display("FAIL wrap_strobe_count got %0d want 2", got_addr_q.size());
        end else begin
            if ({got_addr_q[0], got_data_q[0]} !== {7'h7F, 8'h11}) begin n_fail++; $display("FAIL wrap_strobe0 got %h/%h want 7f/11", got_addr_q[0], got_data_q[0]); end
            n_checks++;
            if ({got_addr_q[1], got_data_q[1]} !== {7'h00, 8'h22}) begin n_fail++; $display("FAIL wrap_strobe1 got %h/%h want 00/22", got_addr_q[1], got_data_q[1]); end
        end
        n_checks++;
        if (ptr !== 7'd1) begin n_fail++; $display("FAIL wrap_ptr got %0d want 1", ptr); end n_checks++;
        do_read(1'b1, 8'h7F, 2, nk);
        if ({rx_data[0], rx_data[1]} !== {8'h11, 8'h22}) begin n_fail++; $display("FAIL wrap_readback got %h %h want 11 22", rx_data[0], rx_data[1]); end n_checks++;
        if (ptr !== 7'd1) begin n_fail++; $display("FAIL wrap_read_ptr got %0d want 1", ptr); end n_checks++;
        mdl_ptr = 1;
    endtask

    task automatic test_partial_stop();
        logic a0, a1, s;
        clear_q();
        bus_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h10, a1);
        bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b0, s);
        bus_stop();
        #(4*Q);
        mdl_ptr = 'h10;
        if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL ps_acks got %b want 11", {a0, a1}); end n_checks++;
        if (got_addr_q.size() != 0) begin n_fail++; $display("FAIL ps_strobe_count got %0d want 0", got_addr_q.size()); end n_checks++;
        if (ptr !== 7'h10) begin n_fail++; $display("FAIL ps_ptr got %h want 10", ptr); end n_checks++;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL ps_sda_oe got %b want 0", sda_oe); end n_checks++;
    endtask

    // Random mix of write, current-pointer read, and back-to-back write-pointer/read
    task automatic test_random_back_to_back();
        int kind, n, nk;
        logic [7:0] regp;
        for (int it = 0; it < 14; it++) begin
            kind = $urandom_range(0, 2);
            regp = 8'($urandom_range(0, 255));
            clear_q();
            if (kind == 0) begin
                n = $urandom_range(0, 3);
                for (int i = 0; i < n; i++) tx_data[i] = 8'($urandom);
                do_write(regp, n, nk);
                model_write(regp, n);
                if (nk != 0) begin n_fail++; $display("FAIL rnd_wr_acks it%0d got %0d nacks want 0", it, nk); end n_checks++;
                if (got_addr_q.size() != exp_addr_q.size()) begin
                    n_fail++; $display("FAIL rnd_wr_count it%0d got %0d want %0d", it, got_addr_q.size(), exp_addr_q.size());
                end else begin
                    for (int i = 0; i < exp_addr_q.size(); i++) begin
                        if ({got_addr_q[i], got_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
                            n_fail++; $display("FAIL rnd_wr_strobe it%0d got %h/%h want %h/%h", it, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_data_q[i]);
                        end
                        n_checks++;
                    end
                end
                n_checks++;
            end else begin
                n = $urandom_range(1, 3);
                do_read(kind == 2, regp, n, nk);
                if (kind == 2) mdl_ptr = int'(regp) % DEPTH;
                if (nk != 0) begin n_fail++; $display("FAIL rnd_rd_acks it%0d got %0d nacks want 0", it, nk); end n_checks++;
                for (int i = 0; i < n; i++) begin
                    if (rx_data[i] !== mdl_mem[mdl_ptr]) begin
                        n_fail++; $display("FAIL rnd_rd_data it%0d addr %0d got %h want %h", it, mdl_ptr, rx_data[i], mdl_mem[mdl_ptr]);
                    end
                    n_checks++;
                    mdl_ptr = (mdl_ptr + 1) % DEPTH;
                end
                if (got_addr_q.size() != 0) begin n_fail++; $display("FAIL rnd_rd_strobe it%0d got %0d want 0", it, got_addr_q.size()); end n_checks++;
            end
            if (ptr !== 7'(mdl_ptr)) begin n_fail++; $display("FAIL rnd_ptr it%0d got %0d want %0d", it, ptr, mdl_ptr); end n_checks++;
        end
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2;
        int nk;
        tx_data[0] = 8'h0F;
        do_write(8'h20, 1, nk);
        bus_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h20, a1);
        bus_start();
        wr_byte(8'hA1, a2);
        if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rm_driving_zero got %b want 1", sda_oe); end n_checks++;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rm_release got %b want 0", sda_oe); end n_checks++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
        mdl_ptr = 0;
        bus_stop();
        #(4*Q);
        if (ptr !== 7'h00) begin n_fail++; $display("FAIL rm_ptr got %h want 00", ptr); end n_checks++;
        do_read(1'b0, 8'h00, 4, nk);
        for (int i = 0; i < 4; i++) begin
            if (rx_data[i] !== 8'h00) begin n_fail++; $display("FAIL rm_read_lo idx %0d got %h want 00", i, rx_data[i]); end n_checks++;
        end
        do_read(1'b1, 8'h1E, 4, nk);
        for (int i = 0; i < 4; i++) begin
            if (rx_data[i] !== 8'h00) begin n_fail++; $display("FAIL rm_read_mid idx %0d got %h want 00", i, rx_data[i]); end n_checks++;
        end
        do_read(1'b1, 8'h7E, 4, nk);
        for (int i = 0; i < 4; i++) begin
            if (rx_data[i] !== 8'h00) begin n_fail++; $display("FAIL rm_read_wrap idx %0d got %h want 00", i, rx_data[i]); end n_checks++;
        end
        if (ptr !== 7'h02) begin n_fail++; $display("FAIL rm_ptr_end got %h want 02", ptr); end n_checks++;
        mdl_ptr = 2;
    endtask

    task automatic test_oe_stability();
        if (oe_viol != 0) begin n_fail++; $display("FAIL oe_while_scl_high got %0d changes want 0", oe_viol); end n_checks++;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_repeated_start_read();
        test_addr_mismatch();
        test_wrap();
        test_partial_stop();
        test_random_back_to_back();
        test_reset_mid_read();
        test_oe_stability();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
